// File: rtl/i2c_txn_sequencer.sv
// ADT7420 register-read sequencer: pointer write, bus-free gap, two-byte read,
// with per-transaction timeout, bounded retry and exclusive I2C bus ownership.
module i2c_txn_sequencer #(
    parameter int unsigned GAP_CYCLES     = 8,
    parameter int unsigned TIMEOUT_CYCLES = 4096,
    parameter int unsigned MAX_RETRIES    = 3
) (
    input  logic        FSM_Clk,
    input  logic        reset,
    input  logic        START,
    output logic        STARTW,
    output logic        STARTR,
    input  logic        done_w,
    input  logic        error_w,
    input  logic        done_r,
    input  logic        error_r,
    input  logic        SCLW,
    input  logic        SDAW,
    input  logic        SCLR,
    input  logic        SDAR,
    input  logic [7:0]  DATAH,
    input  logic [7:0]  DATAL,
    output logic        SCL,
    output logic        SDA,
    output logic [15:0] result,
    output logic        result_valid,
    output logic        busy,
    output logic        error,
    output logic [1:0]  retries,
    output logic [7:0]  State
);

    localparam int unsigned TW = 16;
    localparam int unsigned GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

    typedef enum logic [3:0] {
        S_IDLE    = 4'd0,
        S_WR_GO   = 4'd1,
        S_WR_WAIT = 4'd2,
        S_GAP     = 4'd3,
        S_RD_GO   = 4'd4,
        S_RD_WAIT = 4'd5,
        S_RETRY   = 4'd6,
        S_DONE    = 4'd7,
        S_ERR     = 4'd8
    } state_e;

    state_e        state_q, state_d;
    logic [TW-1:0] timer_q, timer_d;
    logic [GW-1:0] gap_q, gap_d;
    logic [1:0]    retries_q, retries_d;
    logic [15:0]   result_q, result_d;
    logic          rvalid_q, rvalid_d;
    logic          error_q, error_d;
    logic          start_q;
    logic          startw_q, startr_q, busy_q;

    logic          start_acc;
    logic          timeout_hit;
    logic          gap_end;
    logic [TW-1:0] timer_inc;

    assign start_acc   = START & ~start_q;
    assign timeout_hit = (timer_q == TW'(TIMEOUT_CYCLES - 1));
    assign gap_end     = (gap_q == GW'(GAP_CYCLES - 1));
    // Saturating increment so a stuck engine can never wrap the timer
    assign timer_inc   = (timer_q == '1) ? timer_q : timer_q + TW'(1);

    // Next-state and next-value logic
    always_comb begin
        state_d   = state_q;
        timer_d   = timer_q;
        gap_d     = gap_q;
        retries_d = retries_q;
        result_d  = result_q;
        rvalid_d  = rvalid_q;
        error_d   = error_q;
        case (state_q)
            S_IDLE, S_DONE, S_ERR: begin
                if (start_acc) begin
                    state_d   = S_WR_GO;
                    error_d   = 1'b0;
                    rvalid_d  = 1'b0;
                    retries_d = 2'd0;
                end
            end
            S_WR_GO: begin
                timer_d = '0;
                state_d = S_WR_WAIT;
            end
            S_WR_WAIT: begin
                timer_d = timer_inc;
                if (error_w || timeout_hit) begin
                    gap_d   = '0;
                    state_d = S_RETRY;
                end else if (done_w) begin
                    gap_d   = '0;
                    state_d = S_GAP;
                end
            end
            S_GAP: begin
                if (gap_end) state_d = S_RD_GO;
                else         gap_d   = gap_q + GW'(1);
            end
            S_RD_GO: begin
                timer_d = '0;
                state_d = S_RD_WAIT;
            end
            S_RD_WAIT: begin
                timer_d = timer_inc;
                if (error_r || timeout_hit) begin
                    gap_d   = '0;
                    state_d = S_RETRY;
                end else if (done_r) begin
                    result_d = {DATAH, DATAL};
                    rvalid_d = 1'b1;
                    state_d  = S_DONE;
                end
            end
            S_RETRY: begin
                if (!gap_end) begin
                    gap_d = gap_q + GW'(1);
                end else if (retries_q == 2'(MAX_RETRIES)) begin
                    error_d = 1'b1;
                    state_d = S_ERR;
                end else begin
                    retries_d = retries_q + 2'd1;
                    state_d   = S_WR_GO;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Registered state and outputs; pulses and busy follow the next state
    always_ff @(posedge FSM_Clk or posedge reset) begin
        if (reset) begin
            state_q   <= S_IDLE;
            timer_q   <= '0;
            gap_q     <= '0;
            retries_q <= 2'd0;
            result_q  <= 16'd0;
            rvalid_q  <= 1'b0;
            error_q   <= 1'b0;
            start_q   <= 1'b0;
            startw_q  <= 1'b0;
            startr_q  <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            timer_q   <= timer_d;
            gap_q     <= gap_d;
            retries_q <= retries_d;
            result_q  <= result_d;
            rvalid_q  <= rvalid_d;
            error_q   <= error_d;
            start_q   <= START;
            startw_q  <= (state_d == S_WR_GO);
            startr_q  <= (state_d == S_RD_GO);
            busy_q    <= !(state_d inside {S_IDLE, S_DONE, S_ERR});
        end
    end

    // Bus ownership follows the registered state; released bus idles high
    always_comb begin
        SCL = 1'b1;
        SDA = 1'b1;
        case (state_q)
            S_WR_GO, S_WR_WAIT: begin
                SCL = SCLW;
                SDA = SDAW;
            end
            S_RD_GO, S_RD_WAIT: begin
                SCL = SCLR;
                SDA = SDAR;
            end
            default: begin
                SCL = 1'b1;
                SDA = 1'b1;
            end
        endcase
    end

    assign STARTW       = startw_q;
    assign STARTR       = startr_q;
    assign result       = result_q;
    assign result_valid = rvalid_q;
    assign busy         = busy_q;
    assign error        = error_q;
    assign retries      = retries_q;
    assign State        = 8'(state_q);

endmodule

// File: tb/tb_i2c_txn_sequencer.sv
// Bench for i2c_txn_sequencer: table of whole transactions with scripted
// engine responses, plus hand sequences for latency, timeout and async reset.
module tb_i2c_txn_sequencer;

    logic        FSM_Clk, reset, START;
    logic        done_w, error_w, done_r, error_r;
    logic        SCLW, SDAW, SCLR, SDAR;
    logic [7:0]  DATAH, DATAL;
    logic        STARTW, STARTR, SCL, SDA, result_valid, busy, error;
    logic [15:0] result;
    logic [1:0]  retries;
    logic [7:0]  State;

    logic        to_STARTW, to_STARTR, to_SCL, to_SDA, to_rv, to_busy, to_error;
    logic [15:0] to_result;
    logic [1:0]  to_retries;
    logic [7:0]  to_State;

    int nchk = 0;
    int nerr = 0;
    int nw_cnt = 0;
    int nr_cnt = 0;

    i2c_txn_sequencer dut (
        .FSM_Clk(FSM_Clk), .reset(reset), .START(START),
        .STARTW(STARTW), .STARTR(STARTR),
        .done_w(done_w), .error_w(error_w), .done_r(done_r), .error_r(error_r),
        .SCLW(SCLW), .SDAW(SDAW), .SCLR(SCLR), .SDAR(SDAR),
        .DATAH(DATAH), .DATAL(DATAL), .SCL(SCL), .SDA(SDA),
        .result(result), .result_valid(result_valid), .busy(busy),
        .error(error), .retries(retries), .State(State)
    );

    i2c_txn_sequencer #(.TIMEOUT_CYCLES(16)) dut_to (
        .FSM_Clk(FSM_Clk), .reset(reset), .START(START),
        .STARTW(to_STARTW), .STARTR(to_STARTR),
        .done_w(done_w), .error_w(error_w), .done_r(done_r), .error_r(error_r),
        .SCLW(SCLW), .SDAW(SDAW), .SCLR(SCLR), .SDAR(SDAR),
        .DATAH(DATAH), .DATAL(DATAL), .SCL(to_SCL), .SDA(to_SDA),
        .result(to_result), .result_valid(to_rv), .busy(to_busy),
        .error(to_error), .retries(to_retries), .State(to_State)
    );

    initial FSM_Clk = 1'b0;
    always #5 FSM_Clk = ~FSM_Clk;

    always @(negedge FSM_Clk) begin
        if (STARTW) nw_cnt <= nw_cnt + 1;
        if (STARTR) nr_cnt <= nr_cnt + 1;
    end

    typedef struct {
        logic [7:0]  kinds;      // per attempt, 2 bits: 0 ok, 1 error_w, 2 error_r, 3 done_r+error_r
        logic [7:0]  dh;
        logic [7:0]  dl;
        logic [15:0] exp_res;
        logic [1:0]  exp_retries;
        logic        exp_err;
        logic        exp_rv;
        int          exp_nw;
        int          exp_nr;
        logic [7:0]  exp_state;
    } vec_t;

    vec_t vecs [8];

    task automatic tick();
        @(posedge FSM_Clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic wait_startw();
        int n = 0;
        while (!STARTW && n < 40) begin
            tick();
            n++;
        end
        chk("startw_seen", 32'(STARTW), 32'd1);
    endtask

    task automatic wait_startr();
        int n = 0;
        while (!STARTR && n < 40) begin
            tick();
            n++;
        end
        chk("startr_seen", 32'(STARTR), 32'd1);
    endtask

    task automatic run_vec(input int idx, input vec_t v, input logic [15:0] prev_res);
        int nw0, nr0, n;
        logic [1:0] k;
        logic fin;
        START = 1'b0;
        tick();
        nw0 = nw_cnt;
        nr0 = nr_cnt;
        START = 1'b1;
        fin = 1'b0;
        for (int a = 0; a < 4; a++) begin
            if (!fin) begin
                k = v.kinds[2*a +: 2];
                wait_startw();
                repeat (3) tick();
                if (k == 2'd1) begin
                    error_w = 1'b1;
                    tick();
                    error_w = 1'b0;
                    chk($sformatf("v%0d_a%0d_wr_retry", idx, a), 32'(State), 32'd6);
                    chk($sformatf("v%0d_a%0d_retry_bus", idx, a), 32'({SCL, SDA}), 32'd3);
                    if (a < 3) begin
                        n = 1;
                        while (!STARTW && n < 40) begin
                            tick();
                            n++;
                        end
                        chk($sformatf("v%0d_a%0d_retry_spacing", idx, a), 32'(n), 32'd9);
                    end
                end else begin
                    done_w = 1'b1;
                    tick();
                    done_w = 1'b0;
                    wait_startr();
                    repeat (2) tick();
                    DATAH = v.dh;
                    DATAL = v.dl;
                    error_r = (k != 2'd0);
                    done_r  = (k != 2'd2);
                    tick();
                    error_r = 1'b0;
                    done_r  = 1'b0;
                    if (k == 2'd0) begin
                        fin = 1'b1;
                    end else begin
                        chk($sformatf("v%0d_a%0d_rd_retry", idx, a), 32'(State), 32'd6);
                        chk($sformatf("v%0d_a%0d_res_kept", idx, a), 32'(result), 32'(prev_res));
                    end
                end
            end
        end
        n = 0;
        while (State != 8'd7 && State != 8'd8 && n < 60) begin
            tick();
            n++;
        end
        chk($sformatf("v%0d_state", idx), 32'(State), 32'(v.exp_state));
        chk($sformatf("v%0d_result", idx), 32'(result), 32'(v.exp_res));
        chk($sformatf("v%0d_valid", idx), 32'(result_valid), 32'(v.exp_rv));
        chk($sformatf("v%0d_error", idx), 32'(error), 32'(v.exp_err));
        chk($sformatf("v%0d_retries", idx), 32'(retries), 32'(v.exp_retries));
        chk($sformatf("v%0d_busy", idx), 32'(busy), 32'd0);
        chk($sformatf("v%0d_bus", idx), 32'({SCL, SDA}), 32'd3);
        chk($sformatf("v%0d_nw", idx), 32'(nw_cnt - nw0), 32'(v.exp_nw));
        chk($sformatf("v%0d_nr", idx), 32'(nr_cnt - nr0), 32'(v.exp_nr));
        // START still held high: no further transaction may start
        repeat (10) tick();
        chk($sformatf("v%0d_hold_state", idx), 32'(State), 32'(v.exp_state));
        chk($sformatf("v%0d_hold_nw", idx), 32'(nw_cnt - nw0), 32'(v.exp_nw));
    endtask

    initial begin
        int n, nw0;
        logic [15:0] prev;

        reset = 1'b1; START = 1'b0;
        done_w = 1'b0; error_w = 1'b0; done_r = 1'b0; error_r = 1'b0;
        SCLW = 1'b0; SDAW = 1'b0; SCLR = 1'b0; SDAR = 1'b1;
        DATAH = 8'h00; DATAL = 8'h00;

        vecs[0] = '{8'h00, 8'h0C, 8'h80, 16'h0C80, 2'd0, 1'b0, 1'b1, 1, 1, 8'd7};
        vecs[1] = '{8'h01, 8'h12, 8'h34, 16'h1234, 2'd1, 1'b0, 1'b1, 2, 1, 8'd7};
        vecs[2] = '{8'h02, 8'hAB, 8'hCD, 16'hABCD, 2'd1, 1'b0, 1'b1, 2, 2, 8'd7};
        vecs[3] = '{8'h03, 8'h5A, 8'hA5, 16'h5AA5, 2'd1, 1'b0, 1'b1, 2, 2, 8'd7};
        vecs[4] = '{8'hAA, 8'h11, 8'h22, 16'h5AA5, 2'd3, 1'b1, 1'b0, 4, 4, 8'd8};
        vecs[5] = '{8'h25, 8'h0F, 8'hF0, 16'h0FF0, 2'd3, 1'b0, 1'b1, 4, 2, 8'd7};
        vecs[6] = '{8'h55, 8'h33, 8'h44, 16'h0FF0, 2'd3, 1'b1, 1'b0, 4, 0, 8'd8};
        vecs[7] = '{8'h00, 8'hFF, 8'h01, 16'hFF01, 2'd0, 1'b0, 1'b1, 1, 1, 8'd7};

        repeat (3) tick();
        chk("rst_state", 32'(State), 32'd0);
        chk("rst_bus", 32'({SCL, SDA}), 32'd3);
        chk("rst_pulses", 32'({STARTW, STARTR}), 32'd0);
        chk("rst_result", 32'(result), 32'd0);
        chk("rst_flags", 32'({result_valid, busy, error}), 32'd0);
        chk("rst_retries", 32'(retries), 32'd0);
        reset = 1'b0;
        tick();

        prev = 16'h0000;
        for (int i = 0; i < 8; i++) begin
            run_vec(i, vecs[i], prev);
            prev = vecs[i].exp_res;
        end

        // Nominal latency sequence
        START = 1'b0;
        tick();
        nw0 = nw_cnt;
        START = 1'b1;
        tick();
        chk("nom_startw_latency", 32'(STARTW), 32'd1);
        chk("nom_busy", 32'(busy), 32'd1);
        chk("nom_valid_cleared", 32'(result_valid), 32'd0);
        START = 1'b0;
        repeat (39) tick();
        chk("nom_wr_wait", 32'(State), 32'd2);
        chk("nom_wr_bus", 32'({SCL, SDA}), 32'd0);
        done_w = 1'b1;
        tick();
        done_w = 1'b0;
        chk("nom_gap_state", 32'(State), 32'd3);
        chk("nom_gap_bus", 32'({SCL, SDA}), 32'd3);
        n = 1;
        while (!STARTR && n < 30) begin
            tick();
            n++;
        end
        chk("nom_startr_latency", 32'(n), 32'd9);
        tick();
        chk("nom_rd_bus", 32'({SCL, SDA}), 32'd1);
        START = 1'b1;
        tick();
        START = 1'b0;
        tick();
        chk("nom_start_in_rd_ignored", 32'(State), 32'd5);
        chk("nom_single_startw", 32'(nw_cnt - nw0), 32'd1);
        DATAH = 8'h0C;
        DATAL = 8'h80;
        done_r = 1'b1;
        tick();
        done_r = 1'b0;
        chk("nom_done_state", 32'(State), 32'd7);
        chk("nom_valid_latency", 32'(result_valid), 32'd1);
        chk("nom_result", 32'(result), 32'h0C80);
        chk("nom_busy_done", 32'(busy), 32'd0);
        chk("nom_done_bus", 32'({SCL, SDA}), 32'd3);

        // Timeout on the short-timeout instance: write engine never answers
        reset = 1'b1;
        tick();
        reset = 1'b0;
        START = 1'b0;
        tick();
        START = 1'b1;
        tick();
        chk("to_wr_go", 32'(to_State), 32'd1);
        tick();
        n = 0;
        while (to_State == 8'd2 && n < 40) begin
            n++;
            tick();
        end
        chk("to_wr_wait_cycles", 32'(n), 32'd16);
        chk("to_retry_state", 32'(to_State), 32'd6);
        chk("to_retry_bus", 32'({to_SCL, to_SDA}), 32'd3);

        // Async reset in the middle of a read
        reset = 1'b1;
        tick();
        reset = 1'b0;
        START = 1'b0;
        tick();
        START = 1'b1;
        tick();
        START = 1'b0;
        repeat (2) tick();
        done_w = 1'b1;
        tick();
        done_w = 1'b0;
        wait_startr();
        tick();
        chk("ar_rd_wait", 32'(State), 32'd5);
        #3;
        reset = 1'b1;
        #1;
        chk("ar_state_now", 32'(State), 32'd0);
        chk("ar_bus_now", 32'({SCL, SDA}), 32'd3);
        chk("ar_busy_now", 32'(busy), 32'd0);
        #1;
        reset = 1'b0;
        tick();
        DATAH = 8'hDE;
        DATAL = 8'hAD;
        done_r = 1'b1;
        tick();
        done_r = 1'b0;
        tick();
        chk("ar_late_done_state", 32'(State), 32'd0);
        chk("ar_late_done_result", 32'(result), 32'd0);
        chk("ar_late_done_valid", 32'(result_valid), 32'd0);

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule

// File: doc/i2c_txn_sequencer.md
Name: i2c_txn_sequencer

Overview:
- Sequences one complete ADT7420 register read: a pointer-write transaction on the write engine, then a two-byte read transaction on the read engine.
- Owns the shared I2C_SCL_0/I2C_SDA_0 drive and gives the bus to exactly one engine at a time; the bus is released high when no engine owns it.
- Adds bus-free gap, per-transaction timeout, bounded retry on NACK, and a latched 16-bit result.
- Sits between the okWireIn start/config words and the Write/Read engines.

Parameters:
GAP_CYCLES, 8, FSM_Clk cycles of released bus (SCL=1, SDA=1) between write-STOP and read-START
TIMEOUT_CYCLES, 4096, max FSM_Clk cycles an engine may own the bus before abort
MAX_RETRIES, 3, full write+read retries after engine error before ERR

Ports:
FSM_Clk  input  1  block clock (divided FSM clock)
reset  input  1  asynchronous, active-high reset
START  input  1  level from host wire; rising edge requests a transaction
STARTW  output  1  one-cycle start pulse to write engine
STARTR  output  1  one-cycle start pulse to read engine
done_w  input  1  write engine finished (one-cycle pulse)
error_w  input  1  write engine NACK/error (one-cycle pulse)
done_r  input  1  read engine finished (one-cycle pulse)
error_r  input  1  read engine NACK/error (one-cycle pulse)
SCLW, SDAW  input  1 each  write engine bus drive
SCLR, SDAR  input  1 each  read engine bus drive
DATAH, DATAL  input  8 each  read engine result bytes, valid with done_r
SCL  output  1  muxed bus clock
SDA  output  1  muxed bus data
result  output  16  {DATAH,DATAL} latched on successful read
result_valid  output  1  high from DONE until next accepted START
busy  output  1  high in every state except IDLE, DONE, ERR
error  output  1  sticky high in ERR until next accepted START or reset
retries  output  2  retries consumed in current transaction
State  output  8  current state encoding, for ILA/LEDs

Behaviour:
- Reset (async, any state): state IDLE; SCL=1, SDA=1; STARTW=STARTR=0; result=0; result_valid=0; busy=0; error=0; retries=0; timer=0; start edge register=0. Reset mid-transaction aborts it immediately and releases the bus; no engine output passes through.
- Start detect: START registered each cycle; accepted = START & ~START_q while state in {IDLE, DONE, ERR}. Edges in other states are dropped, not queued. Holding START high gives exactly one transaction.
- Ownership mux (combinational from registered owner): WR -> SCLW/SDAW; RD -> SCLR/SDAR; NONE -> 1/1. No latch inference; every path assigned.
- States (State encoding):
  IDLE(0): owner NONE. Accepted START -> WR_GO; clears error, result_valid, retries.
  WR_GO(1): owner WR, STARTW=1 for this cycle only, timer cleared -> WR_WAIT.
  WR_WAIT(2): owner WR, timer++. error_w -> RETRY. done_w -> GAP (gap counter cleared). timer==TIMEOUT_CYCLES-1 -> RETRY. If error_w and done_w are in the same cycle, error wins.
  GAP(3): owner NONE, counts GAP_CYCLES cycles -> RD_GO.
  RD_GO(4): owner RD, STARTR=1 for one cycle, timer cleared -> RD_WAIT.
  RD_WAIT(5): owner RD, timer++. error_r -> RETRY. done_r -> DONE; same edge latches result={DATAH,DATAL}. Timeout -> RETRY. Error wins over done.
  RETRY(6): owner NONE for GAP_CYCLES cycles. If retries==MAX_RETRIES -> ERR, else retries++ and -> WR_GO.
  DONE(7): owner NONE, result_valid=1; accepted START -> WR_GO (same clears as IDLE).
  ERR(8): owner NONE, error=1, result unchanged; accepted START -> WR_GO.
- Latency, successful first try: STARTW 1 cycle after accepted edge; STARTR exactly GAP_CYCLES+1 cycles after done_w; result_valid 1 cycle after done_r.
- Engine pulses arriving while that engine does not own the bus are ignored.
- Timer is 16-bit and saturates, so it never wraps.

Test Plan:
- Nominal: GAP_CYCLES=8; START rises; done_w 40 cycles after STARTW; done_r with DATAH=8'h0C, DATAL=8'h80 -> STARTR 9 cycles after done_w; result=16'h0C80; result_valid=1; busy=0; SCL=SDA=1 in GAP and DONE.
- Retry: error_w on first attempt, success on second -> retries=1, two STARTW pulses separated by GAP_CYCLES+1 cycles, result latched, error=0.
- Exhaustion: error_r on every attempt, MAX_RETRIES=3 -> 4 STARTW and 4 STARTR pulses total, final state ERR(8), error=1, result_valid=0, bus released.
- Timeout: TIMEOUT_CYCLES=16; write engine never responds -> RETRY entered 16 cycles after WR_GO; SCL/SDA forced to 1 on that cycle.
- Edge handling: START held high across DONE -> no second transaction. START toggled during RD_WAIT -> ignored. Same-cycle done_r and error_r -> RETRY, result unchanged.
- Async reset asserted mid-RD_WAIT, between clock edges -> SCL=SDA=1 and State=0 immediately; a later done_r from the engine has no effect.
